// File: rtl/sum_accumulator.sv
// sum_accumulator: collects COUNT unsigned samples from the adder stage into
// one frame total and hands it downstream with a sticky overflow flag.
module sum_accumulator #(
   parameter int DATA_W = 4,
   parameter int ACC_W  = 5,
   parameter int COUNT  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              out_ovf,
   output logic [7:0]        frame_cnt
);

   typedef enum logic {ACCUM, HOLD} state_t;

   localparam int            SUM_W = ACC_W + 1;
   localparam logic [7:0]    LAST  = 8'(COUNT - 1);

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [7:0]       cnt;
   logic             ovf;
   logic [ACC_W:0]   nsum;
   logic             accept;

   // Input side is open only while accumulating and out of reset.
   assign in_ready = rst_n & (state == ACCUM);
   assign accept   = in_valid & in_ready;

   // Next accumulator value; bit ACC_W is the carry out of the frame width.
   always_comb begin
      nsum = {1'b0, acc} + SUM_W'(in_data);
   end

   // Frame FSM: reset > clear > handoff/accept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ACCUM;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_ovf   <= 1'b0;
         frame_cnt <= '0;
      end else if (clear) begin
         state     <= ACCUM;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (accept) begin
                  acc <= nsum[ACC_W-1:0];
                  ovf <= ovf | nsum[ACC_W];
                  cnt <= cnt + 8'd1;
                  if (cnt == LAST) begin
                     out_sum   <= nsum[ACC_W-1:0];
                     out_ovf   <= ovf | nsum[ACC_W];
                     out_valid <= 1'b1;
                     state     <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  frame_cnt <= frame_cnt + 8'd1;
                  acc       <= '0;
                  cnt       <= '0;
                  ovf       <= 1'b0;
                  state     <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed, table-driven bench for sum_accumulator (COUNT=4, ACC_W=5).
module tb_sum_accumulator;

   logic       clk = 1'b0;
   logic       rst_n, clear, in_valid, in_ready, out_valid, out_ready, out_ovf;
   logic [3:0] in_data;
   logic [4:0] out_sum;
   logic [7:0] frame_cnt;

   int errors = 0;
   int checks = 0;
   int exp_fc = 0;

   sum_accumulator #(.DATA_W(4), .ACC_W(5), .COUNT(4)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_ovf(out_ovf), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] d;      // four samples, d[3:0] sent first
      int          gap;    // idle cycles between samples
      int          sum;
      int          ovf;
   } vec_t;

   vec_t vecs[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic send(input logic [3:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   // Sends four samples; on return the result should be presented.
   task automatic feed(input logic [15:0] d, input int gap);
      for (int i = 0; i < 4; i++) begin
         send(d[i*4 +: 4]);
         if (i != 3)
            for (int g = 0; g < gap; g++) tick();
      end
   endtask

   task automatic handoff(input string name);
      out_ready = 1'b1;
      tick();
      exp_fc = (exp_fc + 1) % 256;
      check({name, " valid after handoff"}, int'(out_valid), 0);
      check({name, " frame_cnt"}, int'(frame_cnt), exp_fc);
   endtask

   initial begin
      vecs[0] = '{16'h4532, 0, 14, 0};
      vecs[1] = '{16'h02FF, 1, 0, 1};
      vecs[2] = '{16'h1111, 2, 4, 0};
      vecs[3] = '{16'hFFFF, 3, 28, 1};
      vecs[4] = '{16'h0000, 0, 0, 0};
      vecs[5] = '{16'h8888, 1, 0, 1};
      vecs[6] = '{16'h001F, 2, 16, 0};

      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      tick();
      check("reset in_ready", int'(in_ready), 0);
      check("reset out_valid", int'(out_valid), 0);
      check("reset out_sum", int'(out_sum), 0);
      check("reset out_ovf", int'(out_ovf), 0);
      check("reset frame_cnt", int'(frame_cnt), 0);
      rst_n = 1'b1;
      #1;
      check("in_ready after reset", int'(in_ready), 1);

      // Table-driven frames
      foreach (vecs[k]) begin
         out_ready = 1'b1;
         feed(vecs[k].d, vecs[k].gap);
         check($sformatf("vec%0d out_valid", k), int'(out_valid), 1);
         check($sformatf("vec%0d out_sum", k), int'(out_sum), vecs[k].sum);
         check($sformatf("vec%0d out_ovf", k), int'(out_ovf), vecs[k].ovf);
         handoff($sformatf("vec%0d", k));
         check($sformatf("vec%0d sum kept", k), int'(out_sum), vecs[k].sum);
      end

      // Backpressure: in_valid held high while stalled in HOLD
      out_ready = 1'b0;
      feed(16'h4532, 0);
      check("bp out_valid", int'(out_valid), 1);
      in_valid = 1'b1; in_data = 4'd9;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("bp in_ready", int'(in_ready), 0);
         check("bp out_valid held", int'(out_valid), 1);
         check("bp out_sum stable", int'(out_sum), 14);
      end
      handoff("bp");
      in_valid = 1'b0;
      feed(16'h1111, 0);
      check("bp next out_sum", int'(out_sum), 4);
      check("bp next out_ovf", int'(out_ovf), 0);
      handoff("bp next");

      // Clear mid-frame, with a sample offered in the clear cycle
      send(4'd7);
      send(4'd7);
      clear = 1'b1; in_valid = 1'b1; in_data = 4'd7;
      tick();
      clear = 1'b0; in_valid = 1'b0;
      check("clear out_valid", int'(out_valid), 0);
      feed(16'h4321, 0);
      check("clear out_sum", int'(out_sum), 10);
      check("clear out_ovf", int'(out_ovf), 0);
      handoff("clear");

      // Clear beats handoff in HOLD: result discarded, not counted
      out_ready = 1'b0;
      feed(16'hFFFF, 0);
      check("clrhold out_valid", int'(out_valid), 1);
      clear = 1'b1; out_ready = 1'b1;
      tick();
      clear = 1'b0;
      check("clrhold out_valid", int'(out_valid), 0);
      check("clrhold frame_cnt", int'(frame_cnt), exp_fc);
      feed(16'h1111, 1);
      check("clrhold fresh sum", int'(out_sum), 4);
      check("clrhold fresh ovf", int'(out_ovf), 0);
      handoff("clrhold");

      // Reset during HOLD
      out_ready = 1'b0;
      feed(16'h8888, 0);
      check("rsthold out_valid", int'(out_valid), 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_fc = 0;
      check("rsthold out_valid", int'(out_valid), 0);
      check("rsthold frame_cnt", int'(frame_cnt), 0);
      check("rsthold out_sum", int'(out_sum), 0);
      check("rsthold out_ovf", int'(out_ovf), 0);
      feed(16'h4532, 0);
      check("rsthold fresh sum", int'(out_sum), 14);
      check("rsthold fresh ovf", int'(out_ovf), 0);
      handoff("rsthold");

      // 256 frames with varying gaps: frame_cnt wraps back to its start value
      for (int f = 0; f < 256; f++) begin
         out_ready = 1'b1;
         feed(16'h4532, f % 4);
         check("wrap out_sum", int'(out_sum), 14);
         tick();
         exp_fc = (exp_fc + 1) % 256;
      end
      check("wrap frame_cnt", int'(frame_cnt), 1);
      check("wrap out_valid", int'(out_valid), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
